// File: rtl/fetch_stage.sv
// Instruction fetch stage: program-load port, local instruction memory, PC sequencing and the IF/ID register.
// Latency: one cycle from PC to IF/ID. Backpressure: stall holds PC and IF/ID; load, redirect and flush take priority over it.
// Halt: a fetched halt opcode parks the stage in HALT until a redirect or reset.
module fetch_stage #(
    parameter int                INSTR_W  = 32,
    parameter int                PC_W     = 32,
    parameter int                ADDR_W   = 8,
    parameter int                PC_STEP  = 2,
    parameter int                RESET_PC = 32,
    parameter int                OPC_W    = 3,
    parameter logic [OPC_W-1:0]  HALT_OPC = 3'b110
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  fetch_idx;
    logic [INSTR_W-1:0] fetch_word;
    logic               fetch_is_halt;

    assign fetch_idx     = pc_out[ADDR_W-1:0];
    assign fetch_word    = mem[fetch_idx];
    assign fetch_is_halt = (fetch_word[INSTR_W-1 -: OPC_W] == HALT_OPC);
    assign halted        = (state == HALT);

    // Memory contents survive reset; only the write itself is blocked on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_out      <= PC_W'(RESET_PC);
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (load_en) begin
            state       <= LOAD;
            if_id_valid <= 1'b0;
        end else if (state == LOAD) begin
            // Leaving a load session restarts the program; nothing is fetched on this edge.
            state  <= RUN;
            pc_out <= PC_W'(RESET_PC);
        end else if (redirect_valid) begin
            state       <= RUN;
            pc_out      <= redirect_pc;
            if_id_valid <= 1'b0;
        end else if (state == HALT) begin
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= fetch_word;
            if_id_pc    <= pc_out;
            if_id_valid <= 1'b1;
            pc_out      <= pc_out + PC_W'(PC_STEP);
            if (fetch_is_halt) begin
                state <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: load, fetch, halt, redirect, stall, flush, wrap and reset cases.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [31:0] pc_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .pc_out         (pc_out),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic vld, input logic [31:0] next_pc);
        chk({tag, ".if_id_pc"},    64'(if_id_pc),    64'(pc));
        chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(instr));
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(vld));
        chk({tag, ".pc_out"},      64'(pc_out),      64'(next_pc));
    endtask

    logic [7:0]  ld_addr [9] = '{8'd36, 8'd40, 8'd42, 8'd44, 8'd254, 8'd0, 8'd50, 8'd32, 8'd34};
    logic [31:0] ld_data [9] = '{32'hC000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'hAAAA_00FE, 32'h5555_0000, 32'h4444_4444,
                                 32'h0028_000F, 32'h6800_0000};

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        chk_ifid("reset", 32'd0, 32'd0, 1'b0, 32'd32);
        chk("reset.halted", 64'(halted), 64'd0);
        reset = 1'b0;

        // Single load session; 32 and 34 written last.
        for (int i = 0; i < 9; i++) begin
            load_en = 1'b1; load_addr = ld_addr[i]; load_data = ld_data[i];
            step();
            chk("load.valid", 64'(if_id_valid), 64'd0);
            chk("load.pc_hold", 64'(pc_out), 64'd32);
        end
        load_en = 1'b0;
        step();
        chk("load_exit.pc", 64'(pc_out), 64'd32);
        chk("load_exit.valid", 64'(if_id_valid), 64'd0);
        step(); chk_ifid("fetch32", 32'd32, 32'h0028_000F, 1'b1, 32'd34);
        step(); chk_ifid("fetch34", 32'd34, 32'h6800_0000, 1'b1, 32'd36);

        // Halt word at 36.
        step(); chk_ifid("halt_fetch", 32'd36, 32'hC000_0000, 1'b1, 32'd38);
        chk("halt_fetch.halted", 64'(halted), 64'd1);
        step();
        chk("halt.valid_drop", 64'(if_id_valid), 64'd0);
        chk("halt.halted", 64'(halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            stall = (i % 3 == 0); flush = (i % 3 == 1);
            step();
            chk("halt.pc_frozen", 64'(pc_out), 64'd38);
            chk("halt.valid_low", 64'(if_id_valid), 64'd0);
            chk("halt.if_id_pc", 64'(if_id_pc), 64'd36);
        end
        stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd32;
        step();
        redirect_valid = 1'b0;
        chk("unhalt.pc", 64'(pc_out), 64'd32);
        chk("unhalt.halted", 64'(halted), 64'd0);
        chk("unhalt.valid", 64'(if_id_valid), 64'd0);
        step(); chk_ifid("unhalt_fetch", 32'd32, 32'h0028_000F, 1'b1, 32'd34);

        // Redirect wins over stall.
        redirect_valid = 1'b1; redirect_pc = 32'd40; stall = 1'b1;
        step();
        chk("redir_stall.pc", 64'(pc_out), 64'd40);
        chk("redir_stall.valid", 64'(if_id_valid), 64'd0);
        redirect_valid = 1'b0; stall = 1'b0;
        step(); chk_ifid("fetch40", 32'd40, 32'h1111_1111, 1'b1, 32'd42);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_ifid("stall", 32'd40, 32'h1111_1111, 1'b1, 32'd42);
        end
        stall = 1'b0;
        step(); chk_ifid("post_stall42", 32'd42, 32'h2222_2222, 1'b1, 32'd44);
        step(); chk_ifid("post_stall44", 32'd44, 32'h3333_3333, 1'b1, 32'd46);

        flush = 1'b1;
        step(); chk_ifid("flush", 32'd44, 32'h3333_3333, 1'b0, 32'd46);
        flush = 1'b0;

        // Index wrap at 2^ADDR_W.
        redirect_valid = 1'b1; redirect_pc = 32'd254;
        step();
        redirect_valid = 1'b0;
        chk("wrap.redir_pc", 64'(pc_out), 64'd254);
        step(); chk_ifid("wrap254", 32'd254, 32'hAAAA_00FE, 1'b1, 32'd256);
        step(); chk_ifid("wrap256", 32'd256, 32'h5555_0000, 1'b1, 32'd258);

        // Reset during a load: write to 50 must be dropped.
        load_en = 1'b1; load_addr = 8'd50; load_data = 32'hDEAD_BEEF; reset = 1'b1;
        step();
        chk_ifid("rst_load", 32'd0, 32'd0, 1'b0, 32'd32);
        chk("rst_load.halted", 64'(halted), 64'd0);
        load_en = 1'b0; reset = 1'b0;
        step(); chk_ifid("rst_load_fetch", 32'd32, 32'h0028_000F, 1'b1, 32'd34);

        // Reset while halted.
        redirect_valid = 1'b1; redirect_pc = 32'd36;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pre_rst_halt.halted", 64'(halted), 64'd1);
        reset = 1'b1;
        step();
        chk_ifid("rst_halt", 32'd0, 32'd0, 1'b0, 32'd32);
        chk("rst_halt.halted", 64'(halted), 64'd0);
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd50;
        step();
        redirect_valid = 1'b0;
        step(); chk_ifid("fetch50", 32'd50, 32'h4444_4444, 1'b1, 32'd52);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
